// File: rtl/ic_pipe_pkg.sv
// Shared instruction-classification definitions: format/function codes and MIPS field constants.
package ic_pipe_pkg;

  localparam int WIDTH_FORMAT = 2;
  localparam int WIDTH_FUNC   = 3;
  localparam int NUM_CNT      = 8;

  typedef enum logic [WIDTH_FORMAT-1:0] {
    FORMAT_R = 2'd0,
    FORMAT_I = 2'd1,
    FORMAT_J = 2'd2
  } format_e;

  typedef enum logic [WIDTH_FUNC-1:0] {
    FUNC_CALC_R    = 3'd0,
    FUNC_CALC_I    = 3'd1,
    FUNC_MEM_READ  = 3'd2,
    FUNC_MEM_WRITE = 3'd3,
    FUNC_BRANCH    = 3'd4,
    FUNC_JUMP      = 3'd5,
    FUNC_MULTDIV   = 3'd6
  } func_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [4:0] RT_BLTZ    = 5'd0;
  localparam logic [4:0] RT_BGEZ    = 5'd1;

endpackage

// File: rtl/ic_pipe_if.sv
// Fetch-side and decode-side valid/ready bundle signals of the classification stage.
interface ic_pipe_if #(parameter int LANES = 2);

  logic                 in_valid;
  logic                 in_ready;
  logic [32*LANES-1:0]  in_instr;
  logic [LANES-1:0]     in_lane_valid;
  logic                 out_valid;
  logic                 out_ready;
  logic [32*LANES-1:0]  out_instr;
  logic [LANES-1:0]     out_lane_valid;
  logic [2*LANES-1:0]   out_format;
  logic [3*LANES-1:0]   out_func;
  logic [LANES-1:0]     out_unknown;

  modport master (
    output in_valid, in_instr, in_lane_valid, out_ready,
    input  in_ready, out_valid, out_instr, out_lane_valid, out_format, out_func, out_unknown
  );

  modport slave (
    input  in_valid, in_instr, in_lane_valid, out_ready,
    output in_ready, out_valid, out_instr, out_lane_valid, out_format, out_func, out_unknown
  );

endinterface

// File: rtl/ic_decode_lane.sv
// Combinational classifier of one 32-bit MIPS word into format, function class and unknown flag.
module ic_decode_lane
  import ic_pipe_pkg::*;
(
  input  logic [31:0] word,
  output format_e     format,
  output func_e       func,
  output logic        unknown
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;

  assign op    = word[31:26];
  assign funct = word[5:0];
  assign rt    = word[20:16];

  wire unused_fields = ^{word[25:21], word[15:6]};

  always_comb begin
    format  = FORMAT_R;
    func    = FUNC_CALC_R;
    unknown = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B:                      func = FUNC_CALC_R;
          6'h08, 6'h09:                      func = FUNC_JUMP;
          6'h10, 6'h11, 6'h12, 6'h13,
          6'h18, 6'h19, 6'h1A, 6'h1B:        func = FUNC_MULTDIV;
          default:                           unknown = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ || rt == RT_BGEZ) begin
          format = FORMAT_I;
          func   = FUNC_BRANCH;
        end else begin
          unknown = 1'b1;
        end
      end
      OP_J, OP_JAL: begin
        format = FORMAT_J;
        func   = FUNC_JUMP;
      end
      6'h04, 6'h05, 6'h06, 6'h07: begin
        format = FORMAT_I;
        func   = FUNC_BRANCH;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        format = FORMAT_I;
        func   = FUNC_CALC_I;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        format = FORMAT_I;
        func   = FUNC_MEM_READ;
      end
      6'h28, 6'h29, 6'h2B: begin
        format = FORMAT_I;
        func   = FUNC_MEM_WRITE;
      end
      default: unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/ic_pipe.sv
// Registered instruction-classification FIFO stage between fetch and decode.
// Per-class performance counters are built only when IC_PIPE_PERF_CNT_EN is defined.
module ic_pipe
  import ic_pipe_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  ic_pipe_if.slave         bus,
  input  logic [2:0]       cnt_sel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_data
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COUNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_W-1:0] DEPTH_C  = COUNT_W'(DEPTH);

  logic [2*LANES-1:0] cls_format;
  logic [3*LANES-1:0] cls_func;
  logic [LANES-1:0]   cls_unknown;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      format_e lane_format;
      func_e   lane_func;
      logic    lane_unknown;

      ic_decode_lane u_decode (
        .word    (bus.in_instr[32*gi +: 32]),
        .format  (lane_format),
        .func    (lane_func),
        .unknown (lane_unknown)
      );

      assign cls_format[2*gi +: 2] = lane_format;
      assign cls_func[3*gi +: 3]   = lane_func;
      assign cls_unknown[gi]       = lane_unknown & bus.in_lane_valid[gi];
    end
  endgenerate

  logic [COUNT_W-1:0] count_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic               push;
  logic               pop;

  logic [32*LANES-1:0] mem_instr   [DEPTH];
  logic [LANES-1:0]    mem_lane_valid [DEPTH];
  logic [2*LANES-1:0]  mem_format  [DEPTH];
  logic [3*LANES-1:0]  mem_func    [DEPTH];
  logic [LANES-1:0]    mem_unknown [DEPTH];

  // Readiness is occupancy-only, so a full FIFO refuses a push even while popping.
  assign bus.in_ready  = (count_reg < DEPTH_C);
  assign bus.out_valid = (count_reg != '0);
  assign push = bus.in_valid && bus.in_ready && !flush;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + COUNT_W'(1);
        2'b01:   count_reg <= count_reg - COUNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_reg]      <= bus.in_instr;
      mem_lane_valid[wr_ptr_reg] <= bus.in_lane_valid;
      mem_format[wr_ptr_reg]     <= cls_format;
      mem_func[wr_ptr_reg]       <= cls_func;
      mem_unknown[wr_ptr_reg]    <= cls_unknown;
    end
  end

  assign bus.out_instr      = bus.out_valid ? mem_instr[rd_ptr_reg]      : '0;
  assign bus.out_lane_valid = bus.out_valid ? mem_lane_valid[rd_ptr_reg] : '0;
  assign bus.out_format     = bus.out_valid ? mem_format[rd_ptr_reg]     : '0;
  assign bus.out_func       = bus.out_valid ? mem_func[rd_ptr_reg]       : '0;
  assign bus.out_unknown    = bus.out_valid ? mem_unknown[rd_ptr_reg]    : '0;

`ifdef IC_PIPE_PERF_CNT_EN
  localparam int INC_W = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_view [NUM_CNT];

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      localparam logic [2:0] CODE = 3'(gi);
      logic [INC_W-1:0] inc;
      logic [CNT_W:0]   sum;
      logic [CNT_W-1:0] value_reg;

      // The last counter tallies unknown lanes; the rest tally their function code.
      always_comb begin
        inc = '0;
        for (int k = 0; k < LANES; k++) begin
          if (bus.in_lane_valid[k] &&
              ((gi == NUM_CNT - 1) ? cls_unknown[k] : (cls_func[3*k +: 3] == CODE)))
            inc = inc + INC_W'(1);
        end
      end

      assign sum = {1'b0, value_reg} + (CNT_W + 1)'(inc);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          value_reg <= '0;
        else if (cnt_clr)
          value_reg <= '0;
        else if (push)
          value_reg <= sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
      end

      assign cnt_view[gi] = value_reg;
    end
  endgenerate

  assign cnt_data = cnt_view[cnt_sel];
`else
  wire unused_cnt_ctrl = ^{cnt_sel, cnt_clr};
  assign cnt_data = '0;
`endif

endmodule

// File: tb/tb_ic_pipe.sv
// Scoreboard bench for ic_pipe: table-driven reference classifier, queue-based FIFO model, counter model.
module tb_ic_pipe;

  localparam int LANES = 2;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic [2:0]       cnt_sel = 3'd0;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] cnt_data;

  always #5 clk = ~clk;

  ic_pipe_if #(.LANES(LANES)) bus ();

  ic_pipe #(.LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .bus      (bus),
    .cnt_sel  (cnt_sel),
    .cnt_clr  (cnt_clr),
    .cnt_data (cnt_data)
  );

  typedef struct {
    logic [63:0] instr;
    logic [1:0]  lv;
    logic [3:0]  fmt;
    logic [5:0]  fn;
    logic [1:0]  unk;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cnt_model[8];
  int   size_before = 0;
  bit   in_reset = 1'b1;

  int op_fmt[64];
  int op_fn[64];
  bit op_ok[64];
  int rf_fn[64];
  bit rf_ok[64];

  function automatic void init_tables();
    for (int f = 0; f < 64; f++) begin
      rf_ok[f] = 1'b1;
      if (f inside {0, 2, 3, 4, 6, 7, [32:39], 42, 43}) rf_fn[f] = 0;
      else if (f inside {8, 9})                        rf_fn[f] = 5;
      else if (f inside {[16:19], [24:27]})            rf_fn[f] = 6;
      else                                             rf_ok[f] = 1'b0;
      op_ok[f]  = 1'b1;
      op_fmt[f] = 1;
      if (f inside {[4:7]})                         op_fn[f] = 4;
      else if (f inside {[8:15]})                   op_fn[f] = 1;
      else if (f inside {32, 33, 35, 36, 37})       op_fn[f] = 2;
      else if (f inside {40, 41, 43})               op_fn[f] = 3;
      else if (f inside {2, 3}) begin op_fmt[f] = 2; op_fn[f] = 5; end
      else                                          op_ok[f] = 1'b0;
    end
  endfunction

  function automatic void classify(input logic [31:0] w, input bit lv,
                                   output int fmt, output int fn, output bit unk);
    int op = int'(w[31:26]);
    fmt = 0; fn = 0; unk = 1'b0;
    if (op == 0) begin
      if (rf_ok[w[5:0]]) fn = rf_fn[w[5:0]];
      else unk = 1'b1;
    end else if (op == 1) begin
      if (w[20:16] <= 5'd1) begin fmt = 1; fn = 4; end
      else unk = 1'b1;
    end else if (op_ok[op]) begin
      fmt = op_fmt[op]; fn = op_fn[op];
    end else begin
      unk = 1'b1;
    end
    if (!lv) unk = 1'b0;
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic int exp_cnt(input int sel);
`ifdef IC_PIPE_PERF_CNT_EN
    return cnt_model[sel];
`else
    return 0 * sel;
`endif
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom();
    logic [5:0] ops[10] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h05, 6'h0C, 6'h23, 6'h2B, 6'h1C, 6'h3F};
    if ($urandom_range(0, 3) != 0) w[31:26] = ops[$urandom_range(0, 9)];
    if (w[31:26] == 6'h01) w[20:16] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  // Monitor: compares DUT outputs to the head of the scoreboard and retires popped bundles.
  always @(negedge clk) begin
    if (!in_reset) begin
      check("in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
      check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      check("cnt_data", 64'(cnt_data), 64'(exp_cnt(int'(cnt_sel))));
      if (q.size() != 0) begin
        check("out_instr", bus.out_instr, q[0].instr);
        check("out_lane_valid", 64'(bus.out_lane_valid), 64'(q[0].lv));
        check("out_format", 64'(bus.out_format), 64'(q[0].fmt));
        check("out_func", 64'(bus.out_func), 64'(q[0].fn));
        check("out_unknown", 64'(bus.out_unknown), 64'(q[0].unk));
      end else begin
        check("empty_zero", 64'({bus.out_lane_valid, bus.out_format, bus.out_func, bus.out_unknown}), 64'd0);
        check("empty_instr", bus.out_instr, 64'd0);
      end
      size_before = q.size();
      if (q.size() != 0 && bus.out_ready) begin
        $display("pop  instr=%h fmt=%h func=%h unk=%b", q[0].instr, q[0].fmt, q[0].fn, q[0].unk);
        void'(q.pop_front());
      end
    end
  end

  // Reference model: predicts FIFO acceptance, flush and counter effects of the upcoming edge.
  always @(negedge clk) begin
    #1;
    if (!in_reset) begin
      if (flush) begin
        q.delete();
      end else if (bus.in_valid && size_before < DEPTH) begin
        exp_t e;
        e.instr = bus.in_instr;
        e.lv    = bus.in_lane_valid;
        for (int k = 0; k < LANES; k++) begin
          int fmt, fn;
          bit unk;
          classify(bus.in_instr[32*k +: 32], bus.in_lane_valid[k], fmt, fn, unk);
          e.fmt[2*k +: 2] = 2'(fmt);
          e.fn[3*k +: 3]  = 3'(fn);
          e.unk[k]        = unk;
          if (bus.in_lane_valid[k]) begin
            cnt_model[fn] = (cnt_model[fn] < CMAX) ? cnt_model[fn] + 1 : CMAX;
            if (unk) cnt_model[7] = (cnt_model[7] < CMAX) ? cnt_model[7] + 1 : CMAX;
          end
        end
        q.push_back(e);
      end
      if (cnt_clr) for (int c = 0; c < 8; c++) cnt_model[c] = 0;
    end
  end

  task automatic drive(input bit v, input logic [31:0] w0, input logic [31:0] w1,
                       input logic [1:0] lv, input bit ordy, input bit fl, input bit clr);
    @(posedge clk);
    #1;
    bus.in_valid      = v;
    bus.in_instr      = {w1, w0};
    bus.in_lane_valid = lv;
    bus.out_ready     = ordy;
    flush             = fl;
    cnt_clr           = clr;
    cnt_sel           = 3'($urandom_range(0, 7));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    in_reset     = 1'b1;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    cnt_clr      = 1'b0;
    cnt_sel      = 3'd0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_cnt0", 64'(cnt_data), 64'd0);
    q.delete();
    for (int c = 0; c < 8; c++) cnt_model[c] = 0;
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    init_tables();
    for (int c = 0; c < 8; c++) cnt_model[c] = 0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_lane_valid = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    drive(1, 32'h00000000, 32'h8C410004, 2'b11, 1, 0, 0);
    drive(1, 32'h0C000010, 32'h04210003, 2'b11, 1, 0, 0);
    drive(1, 32'h04220003, 32'h00000000, 2'b01, 1, 0, 0);
    drive(0, 32'h0, 32'h0, 2'b00, 1, 0, 0);
    cnt_sel = 3'd7;
    @(posedge clk); #1;
    check("unk_cnt", 64'(cnt_data), 64'(exp_cnt(7)));

    for (int i = 0; i < 3; i++) drive(1, rand_word(), rand_word(), 2'b11, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 32'h0, 32'h0, 2'b00, 1, 0, 0);

    drive(1, rand_word(), rand_word(), 2'b11, 0, 0, 0);
    drive(1, rand_word(), rand_word(), 2'b11, 0, 1, 0);
    drive(0, 32'h0, 32'h0, 2'b00, 1, 0, 0);

    for (int i = 0; i < 20; i++) drive(1, 32'h00221820, 32'h00221820, 2'b11, 1, 0, 0);
    drive(0, 32'h0, 32'h0, 2'b00, 1, 0, 0);
    cnt_sel = 3'd0;
    @(posedge clk); #1;
`ifdef IC_PIPE_PERF_CNT_EN
    check("sat_cnt0", 64'(cnt_data), 64'(CMAX));
`else
    check("no_cnt0", 64'(cnt_data), 64'd0);
`endif
    drive(1, 32'h00221820, 32'h00221820, 2'b11, 1, 0, 1);
    drive(0, 32'h0, 32'h0, 2'b00, 1, 0, 0);
    cnt_sel = 3'd0;
    @(posedge clk); #1;
    check("clr_cnt0", 64'(cnt_data), 64'd0);

    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, rand_word(), rand_word(), 2'($urandom()),
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);

    for (int i = 0; i < 3; i++) drive(1, rand_word(), rand_word(), 2'b11, 0, 0, 0);
    do_reset();
    drive(1, 32'h00000000, 32'h8C410004, 2'b11, 1, 0, 0);
    for (int i = 0; i < 100; i++)
      drive($urandom_range(0, 1) != 0, rand_word(), rand_word(), 2'($urandom()),
            $urandom_range(0, 3) != 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 32'h0, 32'h0, 2'b00, 1, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ic_pipe.md
Name: ic_pipe

Overview:
- Parametrised, registered instruction-classification stage for the MIPS pipeline.
- Accepts a bundle of LANES raw 32-bit machine words per beat and decodes each lane into a format class and a function class.
- Buffers classified bundles in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Sits between fetch and decode. Supports flush for branch redirect and optional per-class performance counters.

Parameters:
- LANES, 2, instructions per bundle (≥1).
- DEPTH, 2, FIFO entries (≥1, power of two).
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous FIFO clear.
- in_valid  in  1  bundle offered.
- in_ready  out  1  bundle accepted when in_valid && in_ready.
- in_instr  in  32*LANES  raw words; lane k at bits [32k+31:32k].
- in_lane_valid  in  LANES  per-lane valid mask.
- out_valid  out  1  classified bundle available.
- out_ready  in  1  consumer takes the bundle.
- out_instr  out  32*LANES  words, passed through.
- out_lane_valid  out  LANES  mask, passed through.
- out_format  out  2*LANES  per-lane format.
- out_func  out  3*LANES  per-lane function class.
- out_unknown  out  LANES  per-lane undecodable flag.
- cnt_sel  in  3  selects a function-class counter.
- cnt_clr  in  1  synchronous clear of all counters.
- cnt_data  out  CNT_W  selected counter value.

Behaviour:
- Reset state: FIFO empty, out_valid=0, in_ready=1, all counters 0. Data outputs are 0 while empty.
- Format encoding: R=0, I=1, J=2.
- Function encoding: CALC_R=0, CALC_I=1, MEM_READ=2, MEM_WRITE=3, BRANCH=4, JUMP=5, MULTDIV=6.
- Decode fields: op=[31:26], funct=[5:0], rt=[20:16].
- op=0 (R format):
  - funct 00/02/03/04/06/07/20–27/2A/2B -> CALC_R. An all-zero word (NOP) is CALC_R.
  - funct 08/09 (jr/jalr) -> JUMP.
  - funct 10–13, 18–1B -> MULTDIV.
- op 08–0F -> I/CALC_I.
- op 20/21/23/24/25 -> I/MEM_READ.
- op 28/29/2B -> I/MEM_WRITE.
- op 04–07 -> I/BRANCH.
- op 01 with rt 0 or 1 (bltz/bgez) -> I/BRANCH.
- op 02/03 (j/jal) -> J/JUMP.
- Any other encoding -> format R, func CALC_R, out_unknown=1.
- Masked-off lanes: classified normally but excluded from counters. Their out_unknown is forced to 0.
- Latency: classification is registered at push. An accepted bundle appears at the outputs on the next clock edge, with no combinational in->out path.
- in_ready = (count < DEPTH). It does not depend on out_ready, so a full FIFO with a simultaneous pop still refuses the push.
- Push and pop in the same cycle on a non-full FIFO leave count unchanged.
- Pointers wrap modulo DEPTH.
- flush: count and pointers go to 0 on the next edge and any same-cycle push is dropped. Counters are unaffected by flush.
- Counters:
  - Counter c increments at accept by the number of masked-valid lanes with func==c. Increment range is 0..LANES.
  - Counters saturate at 2^CNT_W−1.
  - cnt_clr has priority over an increment in the same cycle.
  - A flushed push does not count.
  - cnt_sel=7 reads the unknown-lane count.
  - cnt_data is combinational from the counter registers.
- Reset mid-transfer: contents discarded immediately (asynchronous). First post-reset push behaves as from empty.

Optional Feature:
- Macro: IC_PIPE_PERF_CNT_EN.
- When defined: 8 counters as described above.
- When undefined: no counter registers, cnt_data tied to 0, cnt_sel/cnt_clr ignored.
- Handshake and classification are identical either way.

Decomposition:
- Shared header ic_defs: WIDTH_FORMAT=2, WIDTH_FUNC=3, FORMAT_*/FUNC_* codes, opcode/funct/rt constants.
- Sub-module ic_decode_lane: combinational, 32-bit word -> format, func, unknown. Instantiated LANES times via generate.
- ic_pipe holds the FIFO, handshake and counters.

Test Plan:
- LANES=2: lane0 0x00000000, lane1 0x8C410004 pushed, out_ready=1 -> next cycle out_valid=1, format {I,R}, func {MEM_READ,CALC_R}, unknown 0.
- 0x0C000010 (jal) -> J/JUMP.
- 0x04210003 (bgez) -> I/BRANCH.
- 0x04220003 (regimm rt=2) -> R/CALC_R, unknown=1, counter 7 increments.
- DEPTH=2, out_ready=0, three consecutive pushes -> in_ready low after the second, third held. Then out_ready=1 -> bundles drain in order, in_ready high the cycle after the first pop.
- flush asserted together with in_valid on a 1-entry FIFO -> next cycle out_valid=0, count 0, counters unchanged.
- CNT_W=4, 20 bundles of 2 ADD (0x00221820) -> counter 0 reads 15 (saturated). cnt_clr with a same-cycle push -> reads 0.
- reset_n pulsed low mid-stream with FIFO full -> out_valid=0 and in_ready=1 immediately; counters 0.
